// File: rtl/prog_countdown_timer.sv
// Programmable countdown timer: loadable period, one-shot or auto-reload
// mode, enable-gated prescaler, abort, live count, level time-out and a
// registered single-cycle expire pulse.
//
// Handshake: there is none. load and stop are single-cycle commands sampled
// on the rising edge. Priority is reset_n > stop > load > tick. Results
// appear on the registered outputs one cycle after the command edge.
// running and time_out are registered decodes of the FSM state: running=1
// means RUN, time_out=1 means DONE, and both low means IDLE.
module prog_countdown_timer #(
    parameter int WIDTH         = 26,
    parameter int DEFAULT_TICKS = 50000000,
    parameter int PRESCALE      = 1,
    parameter bit AUTO_START    = 1'b1
) (
    input  logic             clk_100Mhz,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             periodic,
    input  logic             enable,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             time_out,
    output logic             expire
);

    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] DEF_N     = WIDTH'(DEFAULT_TICKS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             periodic_q, periodic_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             expire_q, expire_d;
    logic             running_q, running_d;
    logic             time_out_q, time_out_d;
    logic             tick;

    // A tick is the last prescaler phase of an enabled RUN cycle.
    assign tick = (state_q == S_RUN) && enable && (presc_q == PRESC_LAST);

    // Next-state and next-output logic, priority stop > load > tick.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        periodic_d = periodic_q;
        presc_d    = presc_q;
        expire_d   = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            count_d = '0;
            presc_d = '0;
        end else if (load) begin
            reload_d   = load_value;
            periodic_d = periodic;
            presc_d    = '0;
            if (load_value == '0) begin
                // A zero period expires immediately, whatever the mode.
                state_d  = S_DONE;
                count_d  = '0;
                expire_d = 1'b1;
            end else begin
                state_d = S_RUN;
                count_d = load_value - CNT_ONE;
            end
        end else if ((state_q == S_RUN) && enable) begin
            presc_d = tick ? '0 : (presc_q + PRESC_ONE);
            if (tick) begin
                if (count_q != '0) begin
                    count_d = count_q - CNT_ONE;
                end else begin
                    expire_d = 1'b1;
                    if (periodic_q) begin
                        // Reload on the expiring tick so periods abut exactly.
                        count_d = reload_q - CNT_ONE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
        end

        running_d  = (state_d == S_RUN);
        time_out_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_100Mhz) begin
        if (!reset_n) begin
            state_q    <= AUTO_START ? S_RUN : S_IDLE;
            count_q    <= AUTO_START ? (DEF_N - CNT_ONE) : '0;
            reload_q   <= AUTO_START ? DEF_N : '0;
            periodic_q <= 1'b0;
            presc_q    <= '0;
            expire_q   <= 1'b0;
            running_q  <= AUTO_START;
            time_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            periodic_q <= periodic_d;
            presc_q    <= presc_d;
            expire_q   <= expire_d;
            running_q  <= running_d;
            time_out_q <= time_out_d;
        end
    end

    assign count    = count_q;
    assign running  = running_q;
    assign time_out = time_out_q;
    assign expire   = expire_q;

endmodule

// File: doc/prog_countdown_timer.md
Name: prog_countdown_timer

Overview:
Runtime-programmable successor to the fixed 0.5 s countdown timer used for Morse dot/dash/gap timing.
- Adds a loadable period, one-shot or periodic (auto-reload) mode, pause via enable, abort, and a clock prescaler.
- Exposes the live count, a level time-out and a single-cycle expire pulse.
- Sits between the Morse decoder FSM, which loads symbol and gap periods, and the input sampler.

Parameters:
WIDTH, 26, counter and load_value width; maximum period is 2^WIDTH-1 ticks.
DEFAULT_TICKS, 50000000, period loaded at reset when AUTO_START=1 (0.5 s at 100 MHz, PRESCALE=1); must be in 1..2^WIDTH-1.
PRESCALE, 1, clock cycles per tick; must be >=1.
AUTO_START, 1, 1: leave reset counting DEFAULT_TICKS in one-shot mode; 0: leave reset in IDLE.

Ports:
clk_100Mhz  in  1  system clock; all logic on its rising edge.
reset_n  in  1  synchronous, active-low reset.
load  in  1  start/restart pulse; captures load_value and periodic.
load_value  in  WIDTH  period N in ticks.
periodic  in  1  mode sampled on load: 0 one-shot, 1 auto-reload.
enable  in  1  tick gate; low pauses countdown and prescaler, state held.
stop  in  1  abort to IDLE.
count  out  WIDTH  current count register.
running  out  1  high in RUN.
time_out  out  1  level, high in DONE.
expire  out  1  registered one-cycle pulse per expiry.

Behaviour:
- One clock; reset is synchronous and active-low (reset_n sampled on clk_100Mhz rising edge).
- States: IDLE, RUN, DONE. State and all outputs are registered.
- Priority in any cycle: reset_n low > stop > load > tick.
- Reset with AUTO_START=1:
  - state RUN, count=DEFAULT_TICKS-1, reload reg=DEFAULT_TICKS, mode one-shot, prescaler=0.
  - running=1, time_out=0, expire=0.
- Reset with AUTO_START=0: state IDLE, count=0, running=0, time_out=0, expire=0.
- Tick:
  - Prescaler counts 0..PRESCALE-1 only while state=RUN and enable=1.
  - A tick is the cycle in which the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
  - PRESCALE=1 gives a tick on every enabled RUN cycle.
  - Prescaler clears on reset, load and stop.
- load (any state), load_value N>=1:
  - reload reg=N, mode=periodic, count=N-1, prescaler=0, state RUN next cycle.
  - time_out clears.
  - Load during RUN restarts without producing an expire pulse.
- load with N=0: state DONE, count=0, time_out=1, expire pulses next cycle, regardless of periodic.
- RUN on a tick with count!=0: count decrements by 1.
- RUN on a tick with count==0 (expiry):
  - expire=1 in the following cycle.
  - One-shot: state DONE, count stays 0, running=0, time_out=1.
  - Periodic: count=reload-1 and state stays RUN.
- Latency, one-shot: N ticks from the load cycle to the expiring tick.
  - PRESCALE=1 and enable held high: load at cycle 0, expire high at cycle N+1.
  - Reload in periodic mode inserts no extra cycle: expire pulses every N*PRESCALE cycles.
- enable low: count, prescaler and state frozen; load and stop still act.
- stop: state IDLE, count=0, running=0, time_out=0; stop and load in the same cycle resolves to stop.
- DONE and IDLE hold until load or stop; no wrap-around below 0.
- Arithmetic is unsigned and modulo-free; count never underflows.

Test Plan:
- AUTO_START=1, DEFAULT_TICKS=8, PRESCALE=1; release reset_n at cycle 0 -> count 7,6,…,0; time_out rises at the expiring tick +1 (cycle 8); expire high exactly 1 cycle; running falls with it.
- PRESCALE=3, load N=4 one-shot -> count steps every 3 cycles; expire 12 cycles after load+1; time_out stays high until next load.
- Periodic load N=5, PRESCALE=1 -> expire pulses every 5 cycles for 4 periods, time_out stays 0; then stop -> running=0, count=0, no further pulses.
- Pause: load N=10, drop enable for 7 cycles mid-count -> count and prescaler frozen; expiry delayed by exactly 7 cycles.
- Boundaries: load N=1 -> expire at cycle 2; load N=0 -> DONE and expire next cycle; load while count=3 -> restarts at N-1 with no expire; stop+load same cycle -> IDLE.
- reset_n low mid-RUN for one cycle -> all outputs return to reset values next edge; asynchronous glitch between edges has no effect.
